// File: rtl/traffic_light.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_light                                              |
// | Description : Single-approach lamp sequencer (GREEN/YELLOW/RED) with a   |
// |               flashing-yellow attention mode, preferential green, a      |
// |               programmable green extension and a forced-red override.   |
// |               One clock period is 0.5 s.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module traffic_light (
  input  logic       clk,
  input  logic       rst,
  input  logic       attention,
  input  logic       preferential,
  input  logic       force_red,
  input  logic       preset,
  input  logic       preset_add,
  output logic [2:0] leds,
  output logic       lgreen
);

  // Phase lengths in ticks; a phase with limit N is visible for N+1 cycles.
  localparam logic [7:0] GREEN_BASE  = 8'd60;
  localparam logic [7:0] GREEN_PREF  = 8'd80;
  localparam logic [7:0] YELLOW_LAST = 8'd6;
  localparam logic [7:0] RED_LAST    = 8'd4;
  localparam logic [7:0] BLINK_HALF  = 8'd3;
  localparam logic [7:0] BLINK_LAST  = 8'd5;
  localparam logic [3:0] EXT_MAX     = 4'd8;

  localparam logic [2:0] LED_OFF    = 3'b000;
  localparam logic [2:0] LED_GREEN  = 3'b100;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_RED    = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESET = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_RED    = 3'd4,
    S_ATT    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] ext_n_q, ext_n_d;
  logic       lgreen_q, lgreen_d;

  logic [7:0] green_base;
  logic [7:0] ext_ticks;
  logic [7:0] green_limit;

  // Green limit: base plus 20 ticks per extension (20*n = 16*n + 4*n); max 240.
  always_comb begin
    green_base  = preferential ? GREEN_PREF : GREEN_BASE;
    ext_ticks   = {ext_n_q, 4'b0000} + {2'b00, ext_n_q, 2'b00};
    green_limit = green_base + ext_ticks;
  end

  // Next-state logic; priority is attention, then force_red, then normal flow.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ext_n_d  = ext_n_q;
    lgreen_d = 1'b0;

    if (attention) begin
      if (state_q == S_ATT) begin
        // Keep blinking: cnt walks 0..5, lamp is lit in the upper half.
        cnt_d = (cnt_q >= BLINK_LAST) ? 8'd0 : cnt_q + 8'd1;
      end else begin
        state_d = S_ATT;
        cnt_d   = 8'd0;
      end
    end else if (force_red &&
                 (state_q == S_GREEN || state_q == S_YELLOW || state_q == S_RED)) begin
      // Holding cnt at 0 means red runs its full length once released.
      state_d = S_RED;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (preset) begin
            state_d = S_PRESET;
          end else begin
            state_d = S_GREEN;
            cnt_d   = 8'd0;
          end
        end
        S_PRESET: begin
          if (preset_add && (ext_n_q < EXT_MAX)) begin
            ext_n_d  = ext_n_q + 4'd1;
            lgreen_d = 1'b1;
          end
          if (!preset) begin
            state_d = S_GREEN;
            cnt_d   = 8'd0;
          end
        end
        S_GREEN: begin
          if (cnt_q >= green_limit) begin
            state_d = S_YELLOW;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_YELLOW: begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = S_RED;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_RED: begin
          if (cnt_q == RED_LAST) begin
            state_d = S_GREEN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_ATT: begin
          // Attention dropped: resume the cycle from a full red phase.
          state_d = S_RED;
          cnt_d   = 8'd0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset also kills a pending lgreen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      ext_n_q  <= 4'd0;
      lgreen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ext_n_q  <= ext_n_d;
      lgreen_q <= lgreen_d;
    end
  end

  // Moore lamp decode from state and blink phase.
  always_comb begin
    leds = LED_OFF;
    case (state_q)
      S_GREEN:  leds = LED_GREEN;
      S_YELLOW: leds = LED_YELLOW;
      S_RED:    leds = LED_RED;
      S_ATT:    leds = (cnt_q >= BLINK_HALF) ? LED_YELLOW : LED_OFF;
      default:  leds = LED_OFF;
    endcase
  end

  assign lgreen = lgreen_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_traffic_light                                           |
// | Description : Directed-vector bench for traffic_light. Each stimulus     |
// |               cycle queues the lamp/ack values expected after the next   |
// |               clock edge; a separate monitor pops and compares them.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_traffic_light;

  logic       clk;
  logic       rst;
  logic       attention;
  logic       preferential;
  logic       force_red;
  logic       preset;
  logic       preset_add;
  logic [2:0] leds;
  logic       lgreen;

  // Input vector bits: {rst, attention, preferential, force_red, preset, preset_add}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_ATT  = 6'b010000;
  localparam logic [5:0] I_PREF = 6'b001000;
  localparam logic [5:0] I_FR   = 6'b000100;
  localparam logic [5:0] I_PR   = 6'b000010;
  localparam logic [5:0] I_PA   = 6'b000001;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] G   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] R   = 3'b001;

  typedef struct {
    logic [2:0] leds;
    logic       lgreen;
    string      name;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   errors;
  int   checks;
  bit   done;

  traffic_light dut (
    .clk          (clk),
    .rst          (rst),
    .attention    (attention),
    .preferential (preferential),
    .force_red    (force_red),
    .preset       (preset),
    .preset_add   (preset_add),
    .leds         (leds),
    .lgreen       (lgreen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive n cycles of one input vector; each cycle expects (el, eg) after its edge.
  task automatic run(input logic [5:0] iv, input int n, input logic [2:0] el,
                     input logic eg, input string nm);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      {rst, attention, preferential, force_red, preset, preset_add} = iv;
      exp_q.push_back('{leds: el, lgreen: eg, name: nm, idx: k});
    end
  endtask

  // Monitor: the DUT presents a lamp vector every cycle; compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (leds !== e.leds || lgreen !== e.lgreen) begin
          errors++;
          $display("FAIL %s[%0d]: got leds=%b lgreen=%b, expected leds=%b lgreen=%b",
                   e.name, e.idx, leds, lgreen, e.leds, e.lgreen);
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    done   = 1'b0;
    {rst, attention, preferential, force_red, preset, preset_add} = I_RST;

    // Default cycle: 61 green, 7 yellow, 5 red, back to green.
    run(I_RST,  1,  OFF, 1'b0, "def_rst");
    run(I_NONE, 61, G,   1'b0, "def_green");
    run(I_NONE, 7,  Y,   1'b0, "def_yellow");
    run(I_NONE, 5,  R,   1'b0, "def_red");
    run(I_NONE, 1,  G,   1'b0, "def_wrap");

    // Attention from green (force_red alongside must lose), blink, exit to red.
    run(I_RST,        1, OFF, 1'b0, "att_rst");
    run(I_NONE,      10, G,   1'b0, "att_green");
    run(I_ATT | I_FR, 3, OFF, 1'b0, "att_off1");
    run(I_ATT,        3, Y,   1'b0, "att_on1");
    run(I_ATT,        3, OFF, 1'b0, "att_off2");
    run(I_ATT,        3, Y,   1'b0, "att_on2");
    run(I_NONE,       5, R,   1'b0, "att_exit_red");
    run(I_NONE,       1, G,   1'b0, "att_exit_green");
    run(I_ATT,        2, OFF, 1'b0, "att_again");
    run(I_RST,        1, OFF, 1'b0, "att_rst_mid");
    run(I_NONE,       1, G,   1'b0, "att_after_rst");

    // Preferential green; preset_add outside preset mode must be ignored.
    run(I_RST  | I_PREF,         1,  OFF, 1'b0, "pref_rst");
    run(I_PREF | I_PA,           81, G,   1'b0, "pref_green");
    run(I_PREF | I_PA,           7,  Y,   1'b0, "pref_yellow");
    run(I_PREF | I_PA,           5,  R,   1'b0, "pref_red");
    run(I_PREF | I_PA,           1,  G,   1'b0, "pref_wrap");

    // Two extensions: 60 + 2*20 -> 101 green cycles.
    run(I_RST | I_PR,        1,   OFF, 1'b0, "pre_rst");
    run(I_PR  | I_PA,        1,   OFF, 1'b0, "pre_enter");
    run(I_PR  | I_PA,        1,   OFF, 1'b1, "pre_add1");
    run(I_PR,                1,   OFF, 1'b0, "pre_idle1");
    run(I_PR  | I_PA,        1,   OFF, 1'b1, "pre_add2");
    run(I_PR,                1,   OFF, 1'b0, "pre_idle2");
    run(I_NONE,              101, G,   1'b0, "pre_green");
    run(I_NONE,              7,   Y,   1'b0, "pre_yellow");
    run(I_NONE,              5,   R,   1'b0, "pre_red");
    run(I_NONE,              1,   G,   1'b0, "pre_wrap");

    // Saturation at 8 extensions: 60 + 160 -> 221 green cycles.
    run(I_RST | I_PR,        1,   OFF, 1'b0, "sat_rst");
    run(I_PR,                1,   OFF, 1'b0, "sat_enter");
    run(I_PR  | I_PA,        8,   OFF, 1'b1, "sat_add");
    run(I_PR  | I_PA,        2,   OFF, 1'b0, "sat_ignored");
    run(I_NONE,              221, G,   1'b0, "sat_green");
    run(I_NONE,              1,   Y,   1'b0, "sat_yellow");
    // Reset clears the extension count: back to 61 green cycles.
    run(I_RST,               1,   OFF, 1'b0, "ext_clr_rst");
    run(I_NONE,              61,  G,   1'b0, "ext_clr_green");
    run(I_NONE,              1,   Y,   1'b0, "ext_clr_yellow");
    // Reset on the same edge as an accepted add suppresses the ack.
    run(I_RST | I_PR,        1,   OFF, 1'b0, "kill_rst");
    run(I_PR,                1,   OFF, 1'b0, "kill_enter");
    run(I_RST | I_PR | I_PA, 1,   OFF, 1'b0, "kill_pulse");
    run(I_PR,                1,   OFF, 1'b0, "kill_reenter");

    // Force red: first green cycle still shows, then red held. The last held
    // cycle is red with cnt=0, so after release 4 more reds complete the 5.
    run(I_RST,  1,  OFF, 1'b0, "fr_rst");
    run(I_FR,   1,  G,   1'b0, "fr_first_green");
    run(I_FR,   20, R,   1'b0, "fr_hold");
    run(I_NONE, 4,  R,   1'b0, "fr_release_red");
    run(I_NONE, 1,  G,   1'b0, "fr_green");
    // Force during yellow jumps straight to a full red phase.
    run(I_NONE, 60, G,   1'b0, "fr_green_rest");
    run(I_NONE, 2,  Y,   1'b0, "fr_yellow");
    run(I_FR,   1,  R,   1'b0, "fr_skip_yellow");
    run(I_NONE, 4,  R,   1'b0, "fr_yel_red");
    run(I_NONE, 1,  G,   1'b0, "fr_yel_green");

    // Reset mid-yellow.
    run(I_RST,  1,  OFF, 1'b0, "ry_rst");
    run(I_NONE, 61, G,   1'b0, "ry_green");
    run(I_NONE, 3,  Y,   1'b0, "ry_yellow");
    run(I_RST,  1,  OFF, 1'b0, "ry_rst_mid");
    run(I_NONE, 1,  G,   1'b0, "ry_after");

    // Let the monitor drain the final entry, then confirm nothing was left.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: got no completion, expected completion by 200000");
      $fatal(1, "timeout");
    end
  end

endmodule
`default_nettype wire
